// File: rtl/bisection_pkg.sv
// Shared definitions for the bisection search sequencer.
//   state_e         : FSM state encoding
//   DEF_*           : default parameter values
//   clog2()         : ceiling log2, usable in constant expressions
package bisection_pkg;

   localparam int unsigned DEF_BUS_WIDTH     = 10;
   localparam int unsigned DEF_SETTLE_CYCLES = 16;
   localparam int unsigned DEF_MEAS_TIMEOUT  = 1024;
   localparam int unsigned DEF_MAX_ITER      = 12;
   localparam int unsigned DEF_STABLE_ITERS  = 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_SETTLE,
      ST_TRIG,
      ST_WAIT,
      ST_UPDATE,
      ST_LATCH,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bisection_timer.sv
// Loadable down-counter with a zero flag, shared by the settle and
// measurement-timeout phases of the sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (has priority over dec)
//   dec        : decrement, saturating at zero
//   zero       : count is zero
module bisection_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/bisection_ctrl.sv
// Sequencer for the bisection current-reference search core: re-initialises
// the core, settles, triggers a Q measurement, strobes the core update and
// checks for convergence, with a per-measurement timeout and iteration cap.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, abort          : control (start sampled in IDLE only; abort wins)
//   meas_start/done/value : measurement front-end handshake
//   srch_*, q_measured    : search core controls and measured value
//   i_ref                 : current midpoint from the core
//   busy, done, err_*     : status (done/err_* sticky until next start)
//   i_ref_final, iter_count : converged result, completed iterations
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | one-cycle core re-initialisation pulse
// SETTLE | waiting for DAC / current reference to settle
// TRIG   | one-cycle measurement trigger
// WAIT   | waiting for meas_done or timeout
// UPDATE | one-cycle core update strobe
// LATCH  | two cycles for core bounds then midpoint to update
// CHECK  | convergence / iteration-cap decision
// DONE   | converged, hold until start released
// ERROR  | timeout or no convergence, hold until start released
module bisection_ctrl
   import bisection_pkg::*;
#(
   parameter int unsigned BUS_WIDTH     = DEF_BUS_WIDTH,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned MEAS_TIMEOUT  = DEF_MEAS_TIMEOUT,
   parameter int unsigned MAX_ITER      = DEF_MAX_ITER,
   parameter int unsigned STABLE_ITERS  = DEF_STABLE_ITERS
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              abort,
   output logic                              meas_start,
   input  logic                              meas_done,
   input  logic [BUS_WIDTH-1:0]              meas_value,
   output logic                              srch_rst,
   output logic                              srch_enable,
   output logic                              srch_mux,
   output logic                              srch_ready,
   output logic [BUS_WIDTH-1:0]              q_measured,
   input  logic [BUS_WIDTH-1:0]              i_ref,
   output logic                              busy,
   output logic                              done,
   output logic                              err_timeout,
   output logic                              err_noconv,
   output logic [BUS_WIDTH-1:0]              i_ref_final,
   output logic [clog2(MAX_ITER+1)-1:0]      iter_count
);

   localparam int unsigned IW   = clog2(MAX_ITER + 1);
   localparam int unsigned SW   = clog2(STABLE_ITERS + 1);
   localparam int unsigned TMAX = (SETTLE_CYCLES > MEAS_TIMEOUT) ? SETTLE_CYCLES : MEAS_TIMEOUT;
   localparam int unsigned TW   = clog2(TMAX + 1);

   // Timer reaches zero on the last cycle of the phase it times.
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   // The timeout is counted from the trigger cycle, so WAIT itself runs one
   // cycle shorter than MEAS_TIMEOUT.
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(MEAS_TIMEOUT - 2);
   localparam logic [TW-1:0] LATCH_LOAD   = TW'(1);
   localparam logic [IW-1:0] ITER_MAX     = IW'(MAX_ITER);
   localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_ITERS);

   state_e                state_q, state_d;
   logic [BUS_WIDTH-1:0]  q_meas_q, q_meas_d;
   logic [BUS_WIDTH-1:0]  prev_iref_q, prev_iref_d;
   logic [BUS_WIDTH-1:0]  iref_final_q, iref_final_d;
   logic [IW-1:0]         iter_q, iter_d, iter_inc;
   logic [SW-1:0]         stable_q, stable_d, stable_inc;
   logic                  done_q, done_d;
   logic                  err_to_q, err_to_d;
   logic                  err_nc_q, err_nc_d;

   logic                  tmr_load, tmr_dec, tmr_zero;
   logic [TW-1:0]         tmr_val;

   bisection_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      q_meas_d     = q_meas_q;
      prev_iref_d  = prev_iref_q;
      iref_final_d = iref_final_q;
      iter_d       = iter_q;
      stable_d     = stable_q;
      done_d       = done_q;
      err_to_d     = err_to_q;
      err_nc_d     = err_nc_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      tmr_dec      = 1'b0;
      meas_start   = 1'b0;
      srch_rst     = 1'b0;
      srch_ready   = 1'b0;
      srch_enable  = 1'b0;
      srch_mux     = 1'b0;
      busy         = 1'b0;
      iter_inc     = (iter_q == '1) ? iter_q : iter_q + 1'b1;
      stable_inc   = '0;
      if (i_ref == prev_iref_q) begin
         stable_inc = (stable_q == '1) ? stable_q : stable_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_d   = 1'b0;
               err_to_d = 1'b0;
               err_nc_d = 1'b0;
               iter_d   = '0;
               stable_d = '0;
               state_d  = ST_INIT;
            end
         end
         ST_INIT: begin
            busy     = 1'b1;
            srch_rst = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            busy        = 1'b1;
            srch_enable = 1'b1;
            srch_mux    = 1'b1;
            if (tmr_zero) state_d = ST_TRIG;
            else          tmr_dec = 1'b1;
         end
         ST_TRIG: begin
            busy        = 1'b1;
            srch_enable = 1'b1;
            srch_mux    = 1'b1;
            meas_start  = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = TIMEOUT_LOAD;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            busy        = 1'b1;
            srch_enable = 1'b1;
            srch_mux    = 1'b1;
            if (meas_done) begin
               q_meas_d = meas_value;
               state_d  = ST_UPDATE;
            end else if (tmr_zero) begin
               err_to_d = 1'b1;
               state_d  = ST_ERROR;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_UPDATE: begin
            busy        = 1'b1;
            srch_enable = 1'b1;
            srch_mux    = 1'b1;
            srch_ready  = 1'b1;
            prev_iref_d = i_ref;
            tmr_load    = 1'b1;
            tmr_val     = LATCH_LOAD;
            state_d     = ST_LATCH;
         end
         ST_LATCH: begin
            busy        = 1'b1;
            srch_enable = 1'b1;
            srch_mux    = 1'b1;
            if (tmr_zero) state_d = ST_CHECK;
            else          tmr_dec = 1'b1;
         end
         ST_CHECK: begin
            busy        = 1'b1;
            srch_enable = 1'b1;
            srch_mux    = 1'b1;
            iter_d      = iter_inc;
            stable_d    = stable_inc;
            // Convergence is checked first so a result found on the last
            // allowed iteration still counts as converged.
            if (stable_inc >= STABLE_MAX) begin
               iref_final_d = i_ref;
               done_d       = 1'b1;
               state_d      = ST_DONE;
            end else if (iter_inc >= ITER_MAX) begin
               err_nc_d = 1'b1;
               state_d  = ST_ERROR;
            end else begin
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LOAD;
               state_d  = ST_SETTLE;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (!start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides any transition and any flag/counter change made
      // in the same cycle.
      if (abort) begin
         state_d      = ST_IDLE;
         done_d       = done_q;
         err_to_d     = err_to_q;
         err_nc_d     = err_nc_q;
         iter_d       = iter_q;
         stable_d     = stable_q;
         iref_final_d = iref_final_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         q_meas_q     <= '0;
         prev_iref_q  <= '0;
         iref_final_q <= '0;
         iter_q       <= '0;
         stable_q     <= '0;
         done_q       <= 1'b0;
         err_to_q     <= 1'b0;
         err_nc_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         q_meas_q     <= q_meas_d;
         prev_iref_q  <= prev_iref_d;
         iref_final_q <= iref_final_d;
         iter_q       <= iter_d;
         stable_q     <= stable_d;
         done_q       <= done_d;
         err_to_q     <= err_to_d;
         err_nc_q     <= err_nc_d;
      end
   end

   assign q_measured  = q_meas_q;
   assign i_ref_final = iref_final_q;
   assign iter_count  = iter_q;
   assign done        = done_q;
   assign err_timeout = err_to_q;
   assign err_noconv  = err_nc_q;

endmodule

// File: tb/tb_bisection_ctrl.sv
// Directed bench for bisection_ctrl with a behavioural search core and a
// measurement front-end responder.
module tb_bisection_ctrl;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned TMO    = 32;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       meas_start;
   logic       meas_done;
   logic [9:0] meas_value;
   logic       srch_rst;
   logic       srch_enable;
   logic       srch_mux;
   logic       srch_ready;
   logic [9:0] q_measured;
   logic [9:0] i_ref;
   logic       busy;
   logic       done;
   logic       err_timeout;
   logic       err_noconv;
   logic [9:0] i_ref_final;
   logic [3:0] iter_count;

   int n_assert;
   int n_fail;
   int rst_cnt;
   int rdy_cnt;
   int since_chg;
   int pend;
   int fe_lat;
   bit fe_en;
   bit alt_mode;
   bit spacing_bad;
   logic [9:0] last_iref;
   logic [9:0] lo, hi;
   logic       rdy_d1;

   bisection_ctrl #(
      .BUS_WIDTH     (10),
      .SETTLE_CYCLES (SETTLE),
      .MEAS_TIMEOUT  (TMO),
      .MAX_ITER      (12),
      .STABLE_ITERS  (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .meas_start  (meas_start),
      .meas_done   (meas_done),
      .meas_value  (meas_value),
      .srch_rst    (srch_rst),
      .srch_enable (srch_enable),
      .srch_mux    (srch_mux),
      .srch_ready  (srch_ready),
      .q_measured  (q_measured),
      .i_ref       (i_ref),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout),
      .err_noconv  (err_noconv),
      .i_ref_final (i_ref_final),
      .iter_count  (iter_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Search core: bounds move on the srch_ready edge, midpoint one edge later.
   always @(posedge clk) begin
      if (!rst_n) begin
         lo     <= '0;
         hi     <= '0;
         i_ref  <= '0;
         rdy_d1 <= 1'b0;
      end else begin
         rdy_d1 <= srch_ready;
         if (srch_rst) begin
            lo    <= 10'd0;
            hi    <= 10'd1023;
            i_ref <= alt_mode ? 10'd100 : 10'd511;
         end else if (srch_ready) begin
            if (q_measured < 10'd512) lo <= i_ref;
            else                      hi <= i_ref;
         end else if (rdy_d1) begin
            if (alt_mode) i_ref <= (i_ref == 10'd100) ? 10'd101 : 10'd100;
            else          i_ref <= 10'((11'(lo) + 11'(hi)) >> 1);
         end
      end
   end

   // Front-end responder and event monitor.
   always @(negedge clk) begin
      meas_done = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            meas_done  = 1'b1;
            meas_value = (i_ref >= 10'd300) ? 10'd512 : 10'd200;
         end
      end
      if (meas_start && fe_en) pend = fe_lat;
      if (srch_rst)   rst_cnt = rst_cnt + 1;
      if (srch_ready) rdy_cnt = rdy_cnt + 1;
      if (i_ref !== last_iref) since_chg = 0;
      else if (since_chg < 1000) since_chg = since_chg + 1;
      last_iref = i_ref;
      if (meas_start && (since_chg < int'(SETTLE))) spacing_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int max);
      int cnt;
      cnt = 0;
      while (!(done || err_timeout || err_noconv) && cnt < max) begin
         @(negedge clk);
         cnt++;
      end
      check(tag, 32'(cnt < max), 32'd1);
   endtask

   task automatic wait_meas_start(input string tag, input int max);
      int cnt;
      cnt = 0;
      while (!meas_start && cnt < max) begin
         @(negedge clk);
         cnt++;
      end
      check(tag, 32'(cnt < max), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctl"}, 32'({meas_start, srch_rst, srch_enable, srch_mux, srch_ready,
                                busy, done, err_timeout, err_noconv}), 32'd0);
      check({tag, "_q"},     32'(q_measured),  32'd0);
      check({tag, "_final"}, 32'(i_ref_final), 32'd0);
      check({tag, "_iter"},  32'(iter_count),  32'd0);
   endtask

   initial begin
      int r0;
      int d0;
      int cnt;
      n_assert    = 0;
      n_fail      = 0;
      rst_cnt     = 0;
      rdy_cnt     = 0;
      since_chg   = 0;
      pend        = 0;
      fe_lat      = 3;
      fe_en       = 1'b1;
      alt_mode    = 1'b0;
      spacing_bad = 1'b0;
      last_iref   = '0;
      meas_done   = 1'b0;
      meas_value  = '0;
      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: full search, fixed point of the core model is 299 after 12 iterations
      r0 = rst_cnt;
      pulse_start();
      wait_end("t1_end", 2000);
      check("t1_done",    32'(done),        32'd1);
      check("t1_final",   32'(i_ref_final), 32'd299);
      check("t1_iter",    32'(iter_count),  32'd12);
      check("t1_errs",    32'({err_timeout, err_noconv}), 32'd0);
      check("t1_rst_cnt", 32'(rst_cnt - r0), 32'd1);
      check("t1_spacing", 32'(spacing_bad), 32'd0);
      repeat (2) @(negedge clk);
      check("t1_idle_busy", 32'(busy), 32'd0);

      // 5: reset mid-SETTLE, then a full search with start held high
      pulse_start();
      @(negedge clk);
      check("t5_in_settle", 32'({busy, srch_enable}), 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_zero("t5_reset");
      rst_n = 1'b1;
      @(negedge clk);
      r0 = rst_cnt;
      start = 1'b1;
      wait_end("t5_end", 2000);
      check("t5_done",  32'(done),        32'd1);
      check("t5_final", 32'(i_ref_final), 32'd299);
      check("t5_iter",  32'(iter_count),  32'd12);
      repeat (6) @(negedge clk);
      check("t5_no_retrig", 32'(rst_cnt - r0), 32'd1);
      check("t5_hold_busy", 32'(busy), 32'd0);
      check("t5_hold_done", 32'(done), 32'd1);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // 2: no meas_done -> timeout 32 cycles after the trigger
      fe_en = 1'b0;
      d0 = rdy_cnt;
      pulse_start();
      wait_meas_start("t2_trig", 100);
      cnt = 0;
      while (!err_timeout && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("t2_latency", 32'(cnt), 32'd32);
      check("t2_err_to",  32'(err_timeout), 32'd1);
      check("t2_busy",    32'(busy), 32'd0);
      check("t2_ready",   32'(rdy_cnt - d0), 32'd0);
      check("t2_done",    32'(done), 32'd0);
      fe_en = 1'b1;
      repeat (2) @(negedge clk);

      // 6: meas_done coincides with timeout expiry every iteration
      fe_lat = 31;
      d0 = rdy_cnt;
      pulse_start();
      wait_end("t6_end", 3000);
      check("t6_err_to", 32'(err_timeout), 32'd0);
      check("t6_done",   32'(done),        32'd1);
      check("t6_final",  32'(i_ref_final), 32'd299);
      check("t6_ready",  32'(rdy_cnt - d0), 32'd12);
      repeat (2) @(negedge clk);

      // 4: abort during WAIT, late meas_done ignored
      fe_lat = 10;
      d0 = rdy_cnt;
      pulse_start();
      wait_meas_start("t4_trig", 100);
      repeat (2) @(negedge clk);
      check("t4_in_wait", 32'(busy), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_en",   32'({srch_enable, srch_mux}), 32'd0);
      repeat (15) @(negedge clk);
      check("t4_ready", 32'(rdy_cnt - d0), 32'd0);
      check("t4_flags", 32'({done, err_timeout, err_noconv}), 32'd0);

      // 3: alternating i_ref never converges
      alt_mode = 1'b1;
      fe_lat = 2;
      pulse_start();
      wait_end("t3_end", 2000);
      check("t3_err_nc", 32'(err_noconv),  32'd1);
      check("t3_iter",   32'(iter_count),  32'd12);
      check("t3_done",   32'(done),        32'd0);
      check("t3_err_to", 32'(err_timeout), 32'd0);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bisection_ctrl.md
Name: bisection_ctrl

Overview:
- Sequencer for the bisection current-reference search core.
- Each iteration it:
  - re-initialises the core, then waits for the DAC and current reference to settle;
  - triggers one Q measurement on the front-end and waits for it to complete;
  - presents the result to the core, strobes the core's update, and checks for convergence.
- It enforces a per-measurement timeout and a cap on the number of iterations.
- It sits between the top-level control interface, the measurement front-end and the search core.

Parameters:
- BUS_WIDTH, 10: width of the Q and i_ref buses.
- SETTLE_CYCLES, 16: cycles to wait after an i_ref change before triggering a measurement. Must be 2 or more.
- MEAS_TIMEOUT, 1024: maximum cycles to wait for meas_done.
- MAX_ITER, 12: maximum measure/update iterations before giving up.
- STABLE_ITERS, 2: number of consecutive iterations with an unchanged i_ref that declares convergence.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: level; sampled only in IDLE; begins a search.
- abort, in, 1: returns the block to IDLE on the next edge.
- meas_start, out, 1: one-cycle trigger to the measurement front-end.
- meas_done, in, 1: one-cycle pulse; meas_value is valid while it is high.
- meas_value, in, BUS_WIDTH: measured Q.
- srch_rst, out, 1: active-high one-cycle re-initialisation pulse to the core.
- srch_enable, out, 1: core enable.
- srch_mux, out, 1: core i_ref_mux select.
- srch_ready, out, 1: one-cycle update strobe to the core.
- q_measured, out, BUS_WIDTH: registered measurement value driven to the core.
- i_ref, in, BUS_WIDTH: current midpoint from the core.
- busy, out, 1: high from the INIT state through the CHECK state.
- done, out, 1: sticky convergence flag; cleared by the next start.
- err_timeout, out, 1: sticky; set on measurement timeout.
- err_noconv, out, 1: sticky; set when MAX_ITER is reached.
- i_ref_final, out, BUS_WIDTH: i_ref latched on convergence.
- iter_count, out, clog2(MAX_ITER+1): number of completed iterations.

Behaviour:
- Reset (rst_n low at a clk edge): every output is 0, the FSM is in IDLE, and all counters are 0.
- FSM states: IDLE, INIT, SETTLE, TRIG, WAIT, UPDATE, LATCH, CHECK, DONE, ERROR.
- IDLE:
  - On start=1: clear done, err_*, iter_count and the stable counter; go to INIT.
- INIT: assert srch_rst for exactly 1 cycle; load the settle counter; go to SETTLE.
- srch_enable and srch_mux are 1 in every state from SETTLE through CHECK, and 0 otherwise.
- SETTLE: count SETTLE_CYCLES cycles, then go to TRIG.
- TRIG: assert meas_start for 1 cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - If meas_done=1: q_measured <= meas_value; go to UPDATE.
  - Else if the timeout counter reaches MEAS_TIMEOUT-1: set err_timeout; go to ERROR.
  - A meas_done arriving in any state other than WAIT is ignored.
- UPDATE:
  - Assert srch_ready for 1 cycle. q_measured is already stable.
  - Record prev_iref <= i_ref.
- LATCH:
  - Wait 2 cycles, because the core updates its bounds on the first edge and its midpoint on the second.
  - Then go to CHECK.
- CHECK:
  - iter_count is incremented by 1.
  - If i_ref == prev_iref, increment the stable counter; otherwise clear it.
  - If the stable counter reaches STABLE_ITERS: i_ref_final <= i_ref, set done, go to DONE.
  - Else if iter_count reaches MAX_ITER: set err_noconv, go to ERROR.
  - Else: reload the settle counter and go to SETTLE.
- DONE and ERROR: hold all flags; go to IDLE when start=0.
- Simultaneous events:
  - abort has priority over every transition. It goes to IDLE on the next edge, deasserts busy, srch_enable and srch_mux, and leaves the flags unchanged.
  - If meas_done and the timeout expire in the same cycle, meas_done wins.
- start held high after DONE or ERROR does not retrigger a search. A search starts only when start is sampled high in IDLE.
- Counters saturate and never wrap. All comparisons are unsigned.

Decomposition:
- Shared package bisection_pkg, containing:
  - the state encoding enum;
  - the default constants for BUS_WIDTH, SETTLE_CYCLES, MEAS_TIMEOUT and MAX_ITER;
  - a clog2 helper function.
- One natural sub-module, bisection_timer: a loadable down-counter with a zero flag. It is instantiated once and shared between SETTLE and WAIT.

Test Plan:
1. Behavioural core model, meas_value = 512 when i_ref ≥ 300 and 200 otherwise, q_desired 512, SETTLE_CYCLES=4 -> the following hold:
   - exactly one srch_rst;
   - each meas_start follows the preceding i_ref change by ≥4 cycles;
   - done=1 with i_ref_final equal to the model's fixed point;
   - iter_count ≤ 12.
2. meas_done never asserted, MEAS_TIMEOUT=32 -> err_timeout=1 exactly 32 cycles after meas_start; busy=0; no srch_ready is issued.
3. Core model whose i_ref alternates between 100 and 101 -> err_noconv=1 after iter_count=12; done stays 0.
4. abort asserted during WAIT -> FSM in IDLE on the next edge; srch_enable=0; a later meas_done produces no srch_ready.
5. rst_n driven low mid-SETTLE for one edge -> all outputs 0; a new start runs a full search correctly.
6. meas_done and timeout expiry in the same cycle -> the measurement is accepted, srch_ready pulses, and err_timeout stays 0.
